axi_lite_xbar: RTL
==================

# axi_lite_xbar

- 1-to-3 AXI4-Lite crossbar between the core's memory-side master and the peripheral slaves: SRAM, `uart`, CLINT.
- Decodes each read and write address, then forwards the request to exactly one slave.
- Routes the R/B response back to the master.
- Answers unmapped addresses itself with an error response.
- Read and write paths are independent FSMs. Each allows one outstanding transaction.

## Interface
- `SRAM_BASE`, 32'h8000_0000, SRAM region base
- `SRAM_SIZE`, 32'h0800_0000, SRAM region size in bytes
- `UART_ADDR`, 32'ha000_03f8, UART region base (region size 8 bytes)
- `CLINT_BASE`, 32'h0200_0000, CLINT region base
- `CLINT_SIZE`, 32'h0001_0000, CLINT region size in bytes
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `m`  axi_lite_if.slave  —  upstream master port
- `sram`  axi_lite_if.master  —  SRAM slave port
- `uart`  axi_lite_if.master  —  UART slave port
- `clint`  axi_lite_if.master  —  CLINT slave port

## Operation
- **Decode.** Address hits a region iff `(addr - BASE) < SIZE`, using unsigned 32-bit subtraction, so wrap-around cannot alias. Selection order: SRAM, UART, CLINT; anything else is SEL_NONE.
- **Broadcast and gating.** `araddr`/`awaddr`/`wdata`/`wstrb` go to all slaves. Valid signals go only to the selected slave; the others see valid=0.
- **Read FSM** (states RD_IDLE, RD_FWD, RD_ERR):
  - RD_IDLE:
    - Mapped address: `m.arready` = selected slave's `arready`. On `m.arvalid && m.arready`, latch `rsel` and go to RD_FWD.
    - Unmapped address: `m.arready`=1; the handshake goes to RD_ERR.
  - RD_FWD: `m.rvalid`/`rdata`/`rresp` come from slave `rsel`, and `m.rready` goes to that slave only. Return to RD_IDLE on `m.rvalid && m.rready`.
  - RD_ERR: `m.rvalid`=1, `rdata`=0, `rresp`='1. Return to RD_IDLE on `m.rready`.
  - `m.arready`=0 outside RD_IDLE.
- **Write FSM** (states WR_IDLE, WR_DATA, WR_FWD, WR_ERR):
  - WR_IDLE: AW only is forwarded and W is not; `m.wready`=0. AW handshake is as for reads. On handshake, latch `wsel` (SEL_NONE allowed) and go to WR_DATA.
  - WR_DATA: `wvalid`/`wready` pass through to slave `wsel`. If `wsel`==SEL_NONE, `m.wready`=1 and the data is sunk. On W handshake, go to WR_FWD (mapped) or WR_ERR (unmapped).
  - WR_FWD: B channel is routed from slave `wsel`. Return to WR_IDLE on B handshake.
  - WR_ERR: `m.bvalid`=1, `bresp`='1. Return to WR_IDLE on `m.bready`.
- **Concurrency.** The read and write FSMs run concurrently and may target the same slave. The slave arbitrates between them; the crossbar imposes no ordering between reads and writes.
- **Reset.** Reset mid-transaction returns both FSMs to IDLE and drops the in-flight transfer. Downstream slaves share the same reset.

## Timing
- **Reset values:**
  - All downstream valids = 0.
  - `m.rvalid`=0, `m.bvalid`=0, `m.wready`=0.
  - `m.arready`/`m.awready` are combinational from the decode and the idle state.
- **AR path.** AR forwarding is combinational, 0 added latency. R is visible at the master in the same cycle the slave asserts it.
- **Write latency.** Writes add 1 cycle: AW is accepted in cycle N, and W is forwarded from cycle N+1.
- **Error-response latency.**
  - Read: error `rvalid` asserts the cycle after AR acceptance.
  - Write: error `bvalid` asserts the cycle after W acceptance.
- **Stability.** Valid signals never drop without a handshake, and outputs do not change while valid && !ready. `rsel`/`wsel` are held until the response handshake.
- **Back-to-back.** A new AR is accepted no earlier than the cycle after the R handshake, giving a minimum of 2 cycles per read.

## Structure
- Package `axi_xbar_pkg` contains:
  - `slave_sel_t` enum {SEL_SRAM, SEL_UART, SEL_CLINT, SEL_NONE}
  - `rd_state_t`, `wr_state_t`
  - default region constants
  - function `decode(addr)`, parameterised by base/size arguments
- No sub-module: decode is the package function called twice, once for AR and once for AW. Response steering is a case on the latched select.

## Test plan
- Read 0x8000_0010 with SRAM model rdata=0xDEAD_BEEF → master gets rdata 0xDEAD_BEEF, rresp=0; `uart.arvalid`/`clint.arvalid` stay 0.
- Write 0xA000_03F8, wdata 0x41 → `uart.awvalid` in cycle N, `uart.wvalid` in cycle N+1, master bresp=0.
- Read 0x1000_0000 (unmapped) → arready=1 immediately; next cycle rvalid=1, rdata=0, rresp='1; no slave sees arvalid.
- Write 0xFFFF_FFFC (unmapped, wrap check) → AW and W sunk; bvalid=1 with bresp='1 one cycle after the W handshake.
- Overlap: read CLINT 0x0200_BFF8 while writing SRAM 0x8000_0000, with rready/bready held low 3 cycles → responses held stable, then both complete with resp=0.
- Reset asserted in WR_DATA → next cycle all valids=0, both FSMs IDLE; a following UART write completes normally.

Source files
------------

// File: rtl/axi_xbar_pkg.sv
// Shared types, default address map and the region decoder for the AXI4-Lite crossbar.
package axi_xbar_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef enum logic [1:0] {SEL_SRAM, SEL_UART, SEL_CLINT, SEL_NONE} slave_sel_t;
  typedef enum logic [1:0] {RD_IDLE, RD_FWD, RD_ERR} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_FWD, WR_ERR} wr_state_t;

  localparam logic [31:0] DEF_SRAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] DEF_SRAM_SIZE  = 32'h0800_0000;
  localparam logic [31:0] DEF_UART_ADDR  = 32'ha000_03f8;
  localparam logic [31:0] UART_SIZE      = 32'h0000_0008;
  localparam logic [31:0] DEF_CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] DEF_CLINT_SIZE = 32'h0001_0000;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  // Unsigned offset compare: an address below a base wraps to a huge offset and misses.
  function automatic slave_sel_t decode(
    input logic [31:0] addr,
    input logic [31:0] sram_base,
    input logic [31:0] sram_size,
    input logic [31:0] uart_base,
    input logic [31:0] uart_size,
    input logic [31:0] clint_base,
    input logic [31:0] clint_size
  );
    logic [31:0] off_sram, off_uart, off_clint;
    off_sram  = addr - sram_base;
    off_uart  = addr - uart_base;
    off_clint = addr - clint_base;
    if (off_sram < sram_size)        return SEL_SRAM;
    else if (off_uart < uart_size)   return SEL_UART;
    else if (off_clint < clint_size) return SEL_CLINT;
    else                             return SEL_NONE;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle; master drives requests, slave drives responses.
interface axi_lite_if;
  import axi_xbar_pkg::*;

  logic [AXI_ADDR_W-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_xbar.sv
// 1-to-3 AXI4-Lite crossbar (SRAM, UART, CLINT) with independent single-outstanding
// read and write FSMs and a built-in error responder for unmapped addresses.
module axi_lite_xbar
  import axi_xbar_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE  = DEF_SRAM_BASE,
  parameter logic [31:0] SRAM_SIZE  = DEF_SRAM_SIZE,
  parameter logic [31:0] UART_ADDR  = DEF_UART_ADDR,
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_SIZE = DEF_CLINT_SIZE
) (
  input  logic       clk,
  input  logic       reset,
  axi_lite_if.slave  m,
  axi_lite_if.master sram,
  axi_lite_if.master uart,
  axi_lite_if.master clint
);

  rd_state_t  rd_state_q, rd_state_d;
  wr_state_t  wr_state_q, wr_state_d;
  slave_sel_t rsel_q, rsel_d;
  slave_sel_t wsel_q, wsel_d;
  slave_sel_t ar_sel, aw_sel;
  logic       ar_ready, r_valid;
  logic       aw_ready, w_ready, b_valid;

  assign ar_sel = decode(m.araddr, SRAM_BASE, SRAM_SIZE, UART_ADDR, UART_SIZE,
                         CLINT_BASE, CLINT_SIZE);
  assign aw_sel = decode(m.awaddr, SRAM_BASE, SRAM_SIZE, UART_ADDR, UART_SIZE,
                         CLINT_BASE, CLINT_SIZE);

  assign sram.araddr  = m.araddr;
  assign uart.araddr  = m.araddr;
  assign clint.araddr = m.araddr;
  assign sram.awaddr  = m.awaddr;
  assign uart.awaddr  = m.awaddr;
  assign clint.awaddr = m.awaddr;
  assign sram.wdata   = m.wdata;
  assign uart.wdata   = m.wdata;
  assign clint.wdata  = m.wdata;
  assign sram.wstrb   = m.wstrb;
  assign uart.wstrb   = m.wstrb;
  assign clint.wstrb  = m.wstrb;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rsel_q     <= SEL_NONE;
      wsel_q     <= SEL_NONE;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rsel_q     <= rsel_d;
      wsel_q     <= wsel_d;
    end
  end

  // Read path: AR forwarded combinationally in idle, R steered by the latched select.
  always_comb begin
    rd_state_d    = rd_state_q;
    rsel_d        = rsel_q;
    ar_ready      = 1'b0;
    r_valid       = 1'b0;
    m.rdata       = '0;
    m.rresp       = RESP_OKAY;
    sram.arvalid  = 1'b0;
    uart.arvalid  = 1'b0;
    clint.arvalid = 1'b0;
    sram.rready   = 1'b0;
    uart.rready   = 1'b0;
    clint.rready  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        case (ar_sel)
          SEL_SRAM:  begin sram.arvalid  = m.arvalid; ar_ready = sram.arready;  end
          SEL_UART:  begin uart.arvalid  = m.arvalid; ar_ready = uart.arready;  end
          SEL_CLINT: begin clint.arvalid = m.arvalid; ar_ready = clint.arready; end
          default:   ar_ready = 1'b1;
        endcase
        if (m.arvalid && ar_ready) begin
          rsel_d     = ar_sel;
          rd_state_d = (ar_sel == SEL_NONE) ? RD_ERR : RD_FWD;
        end
      end
      RD_FWD: begin
        case (rsel_q)
          SEL_SRAM: begin
            r_valid = sram.rvalid; m.rdata = sram.rdata; m.rresp = sram.rresp;
            sram.rready = m.rready;
          end
          SEL_UART: begin
            r_valid = uart.rvalid; m.rdata = uart.rdata; m.rresp = uart.rresp;
            uart.rready = m.rready;
          end
          SEL_CLINT: begin
            r_valid = clint.rvalid; m.rdata = clint.rdata; m.rresp = clint.rresp;
            clint.rready = m.rready;
          end
          default: r_valid = 1'b0;
        endcase
        if (r_valid && m.rready) rd_state_d = RD_IDLE;
      end
      RD_ERR: begin
        r_valid = 1'b1;
        m.rresp = RESP_ERR;
        if (m.rready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign m.arready = ar_ready;
  assign m.rvalid  = r_valid;

  // Write path: AW first, W one cycle later, then B from the latched select.
  always_comb begin
    wr_state_d    = wr_state_q;
    wsel_d        = wsel_q;
    aw_ready      = 1'b0;
    w_ready       = 1'b0;
    b_valid       = 1'b0;
    m.bresp       = RESP_OKAY;
    sram.awvalid  = 1'b0;
    uart.awvalid  = 1'b0;
    clint.awvalid = 1'b0;
    sram.wvalid   = 1'b0;
    uart.wvalid   = 1'b0;
    clint.wvalid  = 1'b0;
    sram.bready   = 1'b0;
    uart.bready   = 1'b0;
    clint.bready  = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        case (aw_sel)
          SEL_SRAM:  begin sram.awvalid  = m.awvalid; aw_ready = sram.awready;  end
          SEL_UART:  begin uart.awvalid  = m.awvalid; aw_ready = uart.awready;  end
          SEL_CLINT: begin clint.awvalid = m.awvalid; aw_ready = clint.awready; end
          default:   aw_ready = 1'b1;
        endcase
        if (m.awvalid && aw_ready) begin
          wsel_d     = aw_sel;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        case (wsel_q)
          SEL_SRAM:  begin sram.wvalid  = m.wvalid; w_ready = sram.wready;  end
          SEL_UART:  begin uart.wvalid  = m.wvalid; w_ready = uart.wready;  end
          SEL_CLINT: begin clint.wvalid = m.wvalid; w_ready = clint.wready; end
          default:   w_ready = 1'b1;
        endcase
        if (m.wvalid && w_ready)
          wr_state_d = (wsel_q == SEL_NONE) ? WR_ERR : WR_FWD;
      end
      WR_FWD: begin
        case (wsel_q)
          SEL_SRAM: begin
            b_valid = sram.bvalid; m.bresp = sram.bresp; sram.bready = m.bready;
          end
          SEL_UART: begin
            b_valid = uart.bvalid; m.bresp = uart.bresp; uart.bready = m.bready;
          end
          SEL_CLINT: begin
            b_valid = clint.bvalid; m.bresp = clint.bresp; clint.bready = m.bready;
          end
          default: b_valid = 1'b0;
        endcase
        if (b_valid && m.bready) wr_state_d = WR_IDLE;
      end
      WR_ERR: begin
        b_valid = 1'b1;
        m.bresp = RESP_ERR;
        if (m.bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign m.awready = aw_ready;
  assign m.wready  = w_ready;
  assign m.bvalid  = b_valid;

endmodule
